// File: rtl/fft_frame_sequencer.sv
// Rotates NUM_BANKS sample banks between the audio writer and the FFT loader, then indexes FFT output bins.
// Optional feature macro: OVERRUN_COUNT_EN enables the saturating dropped-sample counter.
module fft_frame_sequencer #(
  parameter int NUM_BANKS = 2,
  parameter int FFT_LEN   = 512
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_clk,
  input  logic [NUM_BANKS-1:0]       bank_full,
  input  logic [NUM_BANKS-1:0]       bank_empty,
  input  logic                       fft_read,
  output logic [NUM_BANKS-1:0]       bank_write,
  output logic [NUM_BANKS-1:0]       bank_read,
  output logic                       reset_fft,
  output logic                       reset_max,
  output logic                       fft_start,
  output logic [$clog2(FFT_LEN)-1:0] output_index,
  output logic                       frame_done,
  output logic                       overrun,
  output logic [7:0]                 overrun_count,
  output logic [2:0]                 fsm_state
);

  localparam int IDX_W = $clog2(FFT_LEN);
  localparam int PTR_W = $clog2(NUM_BANKS);
  localparam logic [PTR_W-1:0] LAST_BANK = PTR_W'(NUM_BANKS - 1);
  localparam logic [IDX_W-1:0] LAST_BIN  = IDX_W'(FFT_LEN - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, START, WAIT, UNLOAD, DONE} state_t;

  state_t           state;
  logic [1:0]       rst_pipe;
  logic             rst;
  logic             sample_q;
  logic             sample_rise;
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [PTR_W-1:0] wp_next;
  logic [PTR_W-1:0] rp_next;
  logic             in_use;
  logic             write_cur;
  logic             write_next;
  logic             drop;

  function automatic logic [NUM_BANKS-1:0] one_hot(input logic [PTR_W-1:0] p);
    return NUM_BANKS'(1) << p;
  endfunction

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_pipe <= 2'b11;
    else       rst_pipe <= {rst_pipe[0], 1'b0};
  end
  assign rst = rst_pipe[1];

  assign sample_rise = sample_clk & ~sample_q;
  assign wp_next     = (wp == LAST_BANK) ? '0 : wp + 1'b1;
  assign rp_next     = (rp == LAST_BANK) ? '0 : rp + 1'b1;
  // During DONE the old read bank is already released, so the writer may move onto it.
  assign in_use      = (state != IDLE) && (state != DONE);
  assign write_cur   = sample_rise && !bank_full[wp];
  assign write_next  = sample_rise && bank_full[wp] && bank_empty[wp_next] &&
                       !(in_use && (wp_next == rp));
  assign drop        = sample_rise && !write_cur && !write_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q   <= 1'b0;
      wp         <= '0;
      bank_write <= '0;
      overrun    <= 1'b0;
    end else begin
      sample_q   <= sample_clk;
      bank_write <= '0;
      overrun    <= drop;
      if (write_cur) begin
        bank_write <= one_hot(wp);
      end else if (write_next) begin
        wp         <= wp_next;
        bank_write <= one_hot(wp_next);
      end
    end
  end

`ifdef OVERRUN_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 overrun_count <= 8'd0;
    else if (drop && overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
  end
`else
  assign overrun_count = 8'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rp           <= '0;
      reset_fft    <= 1'b0;
      reset_max    <= 1'b0;
      fft_start    <= 1'b0;
      output_index <= '0;
      frame_done   <= 1'b0;
    end else begin
      reset_fft  <= 1'b0;
      reset_max  <= 1'b0;
      fft_start  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if ((rp != wp) && bank_full[rp]) begin
            state     <= CLEAR;
            reset_fft <= 1'b1;
            reset_max <= 1'b1;
          end
        end
        CLEAR: state <= LOAD;
        LOAD: begin
          if (bank_empty[rp]) begin
            state     <= START;
            fft_start <= 1'b1;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          output_index <= '0;
          if (fft_read) begin
            state        <= UNLOAD;
            output_index <= IDX_W'(1);
          end
        end
        UNLOAD: begin
          if (fft_read) begin
            output_index <= output_index + 1'b1;
            if (output_index == LAST_BIN) begin
              state      <= DONE;
              frame_done <= 1'b1;
            end
          end
        end
        DONE: begin
          rp           <= rp_next;
          output_index <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read enable drops in the same cycle the bank reports empty.
  assign bank_read = ((state == LOAD) && !bank_empty[rp]) ? one_hot(rp) : '0;
  assign fsm_state = state;

endmodule
